nibble_serial_adder_ctrl: RTL and testbench
===========================================

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand width in 4-bit nibbles; legal range 2..8; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  W  operand A.
REQ-007 SHALL have port b  input  W  operand B.
REQ-008 SHALL have port c_in  input  1  carry-in for nibble 0.
REQ-009 SHALL have port op_sub  input  1  subtract request; present only when SUB_EN is defined.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  W  result word.
REQ-013 SHALL have port c_out  output  1  carry out of the top nibble.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL contain exactly one 4-bit ripple-carry adder datapath (four full-adder stages) shared across all nibbles.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL drive out_valid=1 only in DONE.
REQ-019 On in_valid&&in_ready, SHALL do all of the following:
- capture a, b and c_in (and op_sub when present) into registers;
- clear the nibble counter to 0;
- enter RUN.
REQ-020 In RUN, each cycle SHALL do all of the following:
- add nibble k of A and B together with the carry register;
- write the 4-bit result into sum[4k+3:4k];
- load the stage carry-out into the carry register;
- increment k.
REQ-021 SHALL seed the carry register with c_in at accept.
REQ-022 SHALL leave RUN for DONE after the cycle that processes nibble NIBBLES-1, with c_out = final carry.
REQ-023 Latency: out_valid SHALL rise exactly NIBBLES+1 cycles after the accepting edge (5 cycles for default).
REQ-024 In DONE, sum and c_out SHALL remain stable until out_valid&&out_ready, then SHALL return to IDLE on that edge.
REQ-025 SHALL ignore in_valid while busy; operand inputs SHALL NOT affect an in-flight operation.
REQ-026 Back-to-back: no accept in the same cycle as the out handshake; the earliest next accept SHALL be the cycle after the return to IDLE.
REQ-027 SHALL hold sum bits of unprocessed nibbles at 0 during RUN (cleared at accept).
REQ-028 Nibble counter width SHALL be ceil(log2(NIBBLES)) bits, SHALL not wrap within an operation, and SHALL reset to 0.
REQ-029 Result SHALL equal (A + B + c_in) mod 2^W, with c_out = bit W of the full sum.

Reset
REQ-030 With rst_n=0 at a rising edge, SHALL do all of the following:
- enter IDLE;
- clear the counter, carry register, operand registers, sum and c_out to 0;
- drive out_valid=0 and busy=0.
REQ-031 During reset, in_ready SHALL read 0; it SHALL read 1 on the first cycle after rst_n returns high.
REQ-032 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-033 Macro SERIAL_ADDER_SUB_EN SHALL select subtraction support, with and without the macro as follows:
- Defined: the op_sub port exists. When op_sub=1 is captured, each nibble of B is inverted before the adder and the carry register is seeded with 1 (c_in ignored). Result = A - B mod 2^W; c_out=1 means no borrow.
- Undefined: the op_sub port is absent and the block only adds.

Verification
REQ-034 Scenario 1: NIBBLES=4, a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, out_valid exactly 5 cycles after accept.
REQ-035 Scenario 2: a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, c_out=0. Hold out_ready=0 for 3 cycles -> sum stable, in_ready=0 throughout.
REQ-036 Scenario 3: accept, then change a/b and pulse in_valid while busy -> result unaffected, no second accept, in_ready returns 1 one cycle after the out handshake.
REQ-037 Scenario 4: drive rst_n=0 during the 2nd RUN cycle -> next cycle: IDLE, sum=0, out_valid=0, busy=0; a subsequent a=0x0F0F, b=0x00F1 -> sum=0x1000, c_out=0.
REQ-038 Scenario 5 (SERIAL_ADDER_SUB_EN): a=0x0005, b=0x0007, op_sub=1 -> sum=0xFFFE, c_out=0; a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds W-bit operands one nibble per cycle through a single shared 4-bit ripple adder; SERIAL_ADDER_SUB_EN adds op_sub subtraction
module nibble_serial_adder_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4*NIBBLES,
  localparam int KW      = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         op_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          sub_q, seed, accept, run, last;
  logic [3:0]    na, nb, ns;
  logic [4:0]    c;
`ifdef SERIAL_ADDER_SUB_EN
  logic          sub_d;
  assign sub_d = accept ? op_sub : sub_q;
  assign seed  = op_sub | c_in;
`else
  assign sub_q = 1'b0;
  assign seed  = c_in;
`endif
  assign accept = in_valid && in_ready;
  assign run    = state_q == RUN;
  assign last   = k_q == KW'(NIBBLES-1);
  assign na     = 4'(a_q >> {k_q, 2'b00});
  assign nb     = 4'(b_q >> {k_q, 2'b00}) ^ {4{sub_q}};
  assign c[0]   = carry_q;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign ns[i]  = na[i] ^ nb[i] ^ c[i];
    assign c[i+1] = (na[i] & nb[i]) | (c[i] & (na[i] ^ nb[i]));
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end
  // next state: accept from IDLE, one nibble per RUN cycle, release DONE on out handshake
  always_comb begin
    state_d = state_q == IDLE ? (accept ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  end
  // datapath updates: capture at accept, accumulate one nibble per RUN cycle, counter holds on the last nibble
  always_comb begin
    a_d     = accept ? a : a_q;
    b_d     = accept ? b : b_q;
    k_d     = accept ? '0 : (run && !last) ? KW'(k_q + 1'b1) : k_q;
    carry_d = accept ? seed : run ? c[4] : carry_q;
    sum_d   = accept ? '0 : run ? sum_q | (W'(ns) << {k_q, 2'b00}) : sum_q;
    cout_d  = accept ? 1'b0 : (run && last) ? c[4] : cout_q;
  end
  // outputs decoded from state; in_ready is masked while reset is held
  always_comb begin
    in_ready  = rst_n && state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    sum       = sum_q;
    c_out     = cout_q;
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed vectors against a cycle-count model of the nibble-serial adder
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4*N;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0, op_sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, c_out, busy;
  logic [W-1:0] sum;
  int           vectors = 0, miscompares = 0;
  logic         m_busy = 1'b0, m_clr = 1'b1;
  int           m_cnt = 0;
  logic [W:0]   m_full = '0;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: full-width sum computed at accept, cycles since accept decide visibility
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_clr  <= 1'b1;
    end else if (!m_busy && in_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_clr  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      m_full <= op_sub ? {1'b0, a} + {1'b0, ~b} + (W+1)'(1) : {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
`else
      m_full <= {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
`endif
    end else if (m_busy && m_cnt < N) m_cnt <= m_cnt + 1;
    else if (m_busy && out_ready) m_busy <= 1'b0;
  end

  // compare every cycle, 1 time unit after the edge
  always @(posedge clk) begin
    logic [W:0] mask;
    #1;
    mask = m_cnt >= N ? {1'b0, {W{1'b1}}} : ((W+1)'(1) << (4*m_cnt)) - (W+1)'(1);
    chk("m_in_ready", 32'(in_ready), 32'(rst_n && !m_busy));
    chk("m_out_valid", 32'(out_valid), 32'(m_busy && m_cnt == N));
    chk("m_busy", 32'(busy), 32'(m_busy));
    if (m_busy) chk("m_sum", 32'(sum), 32'(m_full[W-1:0] & mask[W-1:0]));
    if (m_busy && m_cnt == N) chk("m_c_out", 32'(c_out), 32'(m_full[W]));
    if (m_clr) chk("m_sum_clr", 32'({c_out, sum}), 32'(0));
  end

  task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    @(negedge clk);
    a = ta; b = tb; c_in = tc; op_sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'(1));
  endtask

  task automatic finish_op(output logic [W-1:0] rs, output logic rc);
    out_ready = 1'b1;
    rs = sum; rc = c_out;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_hs", 32'(in_ready), 32'(1));
    chk("out_valid_after_hs", 32'(out_valid), 32'(0));
  endtask

  typedef struct {logic [W-1:0] a, b; logic ci; logic [W-1:0] s; logic co;} vec_t;
  vec_t tbl[4] = '{
    '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1},
    '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0},
    '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1}
  };

  initial begin
    int lat;
    logic [W-1:0] rs, s0;
    logic rc;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_outs", 32'({out_valid, busy, c_out, sum}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_post_rst", 32'(in_ready), 32'(1));

    start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_valid(lat);
    chk("s1_latency", 32'(lat), 32'(5));
    finish_op(rs, rc);
    chk("s1_sum", 32'(rs), 32'h0000);
    chk("s1_c_out", 32'(rc), 32'(1));

    start(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_valid(lat);
    s0 = sum;
    for (int i = 0; i < 3; i++) begin
      chk("s2_hold_sum", 32'(sum), 32'(s0));
      chk("s2_hold_in_ready", 32'(in_ready), 32'(0));
      chk("s2_hold_valid", 32'(out_valid), 32'(1));
      @(negedge clk);
    end
    finish_op(rs, rc);
    chk("s2_sum", 32'(rs), 32'h5556);
    chk("s2_c_out", 32'(rc), 32'(0));

    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("s3_in_ready_busy", 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_valid(lat);
    finish_op(rs, rc);
    chk("s3_sum", 32'(rs), 32'h3333);
    chk("s3_c_out", 32'(rc), 32'(0));
    @(negedge clk);
    chk("s3_no_second_accept", 32'(busy), 32'(0));

    start(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("s4_abort_outs", 32'({out_valid, busy, sum}), 32'(0));
    chk("s4_abort_in_ready", 32'(in_ready), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("s4_in_ready_release", 32'(in_ready), 32'(1));
    start(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_valid(lat);
    finish_op(rs, rc);
    chk("s4_sum", 32'(rs), 32'h1000);
    chk("s4_c_out", 32'(rc), 32'(0));

    foreach (tbl[i]) begin
      start(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0);
      wait_valid(lat);
      chk("tbl_latency", 32'(lat), 32'(N+1));
      finish_op(rs, rc);
      chk("tbl_sum", 32'(rs), 32'(tbl[i].s));
      chk("tbl_c_out", 32'(rc), 32'(tbl[i].co));
    end

`ifdef SERIAL_ADDER_SUB_EN
    start(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_valid(lat);
    finish_op(rs, rc);
    chk("s5_sub_sum", 32'(rs), 32'hFFFE);
    chk("s5_sub_c_out", 32'(rc), 32'(0));
    start(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_valid(lat);
    finish_op(rs, rc);
    chk("s5_sub2_sum", 32'(rs), 32'h0002);
    chk("s5_sub2_c_out", 32'(rc), 32'(1));
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
